mul_share_sched: RTL
====================

Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency pipelined array multiplier (WIDTH x WIDTH -> 2*WIDTH, LAT stages) among NREQ requesters.
- Accepts operand pairs via valid/ready and issues at most one multiply per cycle.
- Tags each operation through the pipeline and returns each product to its requester's one-deep result register, held until acknowledged.
- Sits between client blocks and the multiplier instance; the multiplier itself is external.

Parameters:
- WIDTH, 48, operand width in bits.
- NREQ, 4, number of requesters (>=2).
- LAT, 2, multiplier latency in clk edges from operands presented to product valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  per-requester operand-pair valid.
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
- req_ready  output  NREQ  grant; at most one bit set per cycle.
- mul_a  output  WIDTH  operand A to the multiplier, registered.
- mul_b  output  WIDTH  operand B to the multiplier, registered.
- mul_y  input  2*WIDTH  product from the multiplier.
- res_valid  output  NREQ  result register i holds an unacknowledged product.
- res_y  output  NREQ*2*WIDTH  result i at bits [i*2*WIDTH +: 2*WIDTH].
- res_ack  input  NREQ  consumer acknowledge for result i.
- busy  output  1  one or more operations are in flight.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Clears req_ready, mul_a, mul_b, res_valid, res_y, busy, all pipeline tags and pending flags.
  - Sets the round-robin pointer to 0.
  - In-flight operations are discarded; mul_y arriving after reset is ignored because no tag is valid.
- Pending state: pending[i] = (op for i in flight) OR res_valid[i].
- Eligibility: requester i is eligible when req_valid[i]=1 and pending[i]=0.
  - Acknowledging a result does not make the requester eligible in the same cycle; it becomes eligible the following cycle.
- Arbitration (combinational):
  - Among eligible requesters, grant the first one at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 for that requester only; all req_ready bits are 0 if none is eligible.
  - req_ready depends on req_valid, which is allowed.
- Issue: a handshake at edge E (req_valid[g] & req_ready[g]) causes:
  - mul_a <= req_a[g] and mul_b <= req_b[g];
  - tag shift register stage 0 <= {valid=1, id=g};
  - pointer <= (g+1) mod NREQ;
  - pending[g] set.
- No issue at edge E: mul_a and mul_b <= 0, tag stage 0 valid <= 0, pointer unchanged.
- Tag pipeline: LAT stages, shifting every edge unconditionally; the multiplier has no stall.
- Capture: at edge E+LAT, if the last tag stage is valid with id=k:
  - res_y[k] <= mul_y and res_valid[k] <= 1;
  - the in-flight flag for k clears.
  - res_valid therefore rises LAT cycles after the handshake edge.
- Ack: at an edge where res_valid[i] & res_ack[i], res_valid[i] <= 0 and res_y[i] holds its value. res_ack while res_valid=0 is ignored.
- Capture and ack cannot coincide for the same requester, since pending blocks re-issue. Capture for k and ack for j≠k in the same cycle are both performed.
- Throughput:
  - Back-to-back issues from different requesters on consecutive edges are allowed.
  - A single requester sustains at most one op per LAT+2 cycles (issue, LAT, ack, re-eligible).
- busy = OR of tag-valid bits, registered with the tags.
- Products are the full 2*WIDTH bits, unsigned; no truncation.

Test Plan:
- Reset, then req 0 sends a=3, b=5 -> req_ready[0] high same cycle; res_valid[0] rises 2 cycles after the handshake with res_y[0]=15; after res_ack[0], res_valid[0]=0 next cycle.
- All 4 requesters valid from the first cycle after reset -> grants 0,1,2,3 on four consecutive edges; results return in the same order, each LAT cycles after its grant; busy high for exactly those cycles.
- req 2 sends a=b=2^48-1 -> res_y[2]=0xFFFFFFFFFFFE000000000001.
- Req 1 holds res_valid unacked while req_valid[1] stays high -> req_ready[1] stays 0; other requesters keep being granted; ack -> req 1 granted on the following cycle, not the ack cycle.
- Pointer fairness: after granting 3, with reqs 0 and 3 valid again -> grant 0 first, then 3.
- Assert rst_n=0 for one cycle while 2 ops are in flight -> no res_valid rises afterwards; busy=0; pointer=0; a new request from 0 completes normally.

Source files
------------

// File: rtl/mul_share_sched.sv
// -----------------------------------------------------------------------------
// mul_share_sched
//
// Purpose:
//   Round-robin scheduler that lets NREQ requesters share one external,
//   fixed-latency, fully pipelined WIDTH x WIDTH -> 2*WIDTH unsigned multiplier.
//   The scheduler issues at most one operation per cycle. Each operation
//   carries a tag {valid, requester id} down a shift register that matches the
//   multiplier latency. When the tag reaches the end, the product goes into
//   that requester's one-deep result register. The result stays there until
//   the requester acknowledges it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [NREQ]           operand pair valid per requester
//   req_a      in   [NREQ*WIDTH]     operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]     operand B, same packing
//   req_ready  out  [NREQ]           one-hot grant (combinational)
//   mul_a      out  [WIDTH]          registered operand A to the multiplier
//   mul_b      out  [WIDTH]          registered operand B to the multiplier
//   mul_y      in   [2*WIDTH]        product from the multiplier
//   res_valid  out  [NREQ]           result i holds an unacknowledged product
//   res_y      out  [NREQ*2*WIDTH]   result i at [i*2*WIDTH +: 2*WIDTH]
//   res_ack    in   [NREQ]           consumer acknowledge per result
//   busy       out  1                at least one operation in flight
// -----------------------------------------------------------------------------
module mul_share_sched #(
    parameter int WIDTH = 48,
    parameter int NREQ  = 4,
    parameter int LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    input  logic [2*WIDTH-1:0]        mul_y,
    output logic [NREQ-1:0]           res_valid,
    output logic [NREQ*2*WIDTH-1:0]   res_y,
    input  logic [NREQ-1:0]           res_ack,
    output logic                      busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int YW = 2 * WIDTH;

    typedef logic [PW-1:0] id_t;

    // (base + off) mod NREQ. Both base and off are below NREQ, so one
    // conditional subtract is enough.
    function automatic id_t wrap_add(input id_t base, input int off);
        int sum;
        sum = int'(32'(base)) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return id_t'(sum);
    endfunction

    // Round-robin search: return the first eligible requester at or after ptr.
    // Bit PW of the result is the "found" flag. Bits PW-1:0 are the requester id.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] elig,
                                            input id_t ptr);
        logic [PW:0] pick;
        id_t         idx;
        pick = {(PW+1){1'b0}};
        for (int off = 0; off < NREQ; off++) begin
            idx = wrap_add(ptr, off);
            if (!pick[PW] && elig[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    id_t                 r_ptr;
    logic [LAT-1:0]      r_tag_vld;
    id_t                 r_tag_id [LAT];
    logic [NREQ-1:0]     r_inflight;
    logic [NREQ-1:0]     r_res_valid;
    logic [NREQ*YW-1:0]  r_res_y;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;
    logic                r_busy;

    // ------------------------------------------------------------------------
    // Combinational next-state terms
    // ------------------------------------------------------------------------
    logic [NREQ-1:0]     w_pending;
    logic [NREQ-1:0]     w_elig;
    logic [PW:0]         w_pick;
    logic                w_fire;
    id_t                 w_grant_id;
    logic [NREQ-1:0]     w_ready;
    logic [WIDTH-1:0]    w_op_a;
    logic [WIDTH-1:0]    w_op_b;
    logic [NREQ-1:0]     w_cap_vec;
    logic [NREQ-1:0]     w_inflight_nxt;
    logic [NREQ-1:0]     w_res_valid_nxt;
    logic [LAT-1:0]      w_tag_vld_nxt;
    logic                w_busy_nxt;

    // Arbitration: pick a requester and select its operands.
    // The pending mask uses registered res_valid. An ack in this cycle
    // therefore frees the requester only from the next cycle onward.
    always_comb begin
        w_pending  = r_inflight | r_res_valid;
        w_elig     = req_valid & ~w_pending;
        w_pick     = rr_pick(w_elig, r_ptr);
        w_fire     = w_pick[PW];
        w_grant_id = w_pick[PW-1:0];
        w_ready    = {NREQ{w_fire}} & (NREQ'(1'b1) << w_grant_id);
        w_op_a     = {WIDTH{1'b0}};
        w_op_b     = {WIDTH{1'b0}};
        // AND-OR mux. The result is all zeros when nothing is granted, so the
        // multiplier operands drop to zero on idle cycles.
        for (int i = 0; i < NREQ; i++) begin
            w_op_a = w_op_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{w_ready[i]}});
            w_op_b = w_op_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{w_ready[i]}});
        end
    end

    // Tag pipeline, capture decode, and per-requester flag updates.
    always_comb begin
        w_cap_vec = {NREQ{r_tag_vld[LAT-1]}} & (NREQ'(1'b1) << r_tag_id[LAT-1]);
        // A capture and an issue for the same requester cannot occur together.
        // The pending mask blocks that requester until its result is acked.
        w_inflight_nxt  = (r_inflight & ~w_cap_vec) | w_ready;
        // Likewise, a capture and an ack never target the same requester in
        // one cycle, so clearing and setting can be combined freely.
        w_res_valid_nxt = (r_res_valid & ~res_ack) | w_cap_vec;
        w_tag_vld_nxt    = {LAT{1'b0}};
        w_tag_vld_nxt[0] = w_fire;
        for (int s = 1; s < LAT; s++) begin
            w_tag_vld_nxt[s] = r_tag_vld[s-1];
        end
        w_busy_nxt = |w_tag_vld_nxt;
    end

    // Registered state: operands, tags, pointer, flags and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= {PW{1'b0}};
            r_tag_vld   <= {LAT{1'b0}};
            for (int s = 0; s < LAT; s++) begin
                r_tag_id[s] <= {PW{1'b0}};
            end
            r_inflight  <= {NREQ{1'b0}};
            r_res_valid <= {NREQ{1'b0}};
            r_res_y     <= {(NREQ*YW){1'b0}};
            r_mul_a     <= {WIDTH{1'b0}};
            r_mul_b     <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_mul_a     <= w_op_a;
            r_mul_b     <= w_op_b;
            r_tag_vld   <= w_tag_vld_nxt;
            r_tag_id[0] <= w_fire ? w_grant_id : {PW{1'b0}};
            // The tag shift runs every cycle. The multiplier has no stall.
            for (int s = 1; s < LAT; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            if (w_fire) begin
                r_ptr <= wrap_add(w_grant_id, 1);
            end else begin
                r_ptr <= r_ptr;
            end
            r_inflight  <= w_inflight_nxt;
            r_res_valid <= w_res_valid_nxt;
            // A result register changes only on capture. An ack leaves the
            // stored product in place.
            for (int i = 0; i < NREQ; i++) begin
                if (w_cap_vec[i]) begin
                    r_res_y[i*YW +: YW] <= mul_y;
                end else begin
                    r_res_y[i*YW +: YW] <= r_res_y[i*YW +: YW];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign req_ready = w_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;
    assign res_y     = r_res_y;
    assign busy      = r_busy;

endmodule
